bcd2421_seq_ctrl: RTL and testbench

Sequencing controller that converts a packed multi-digit BCD word into packed 2421 code one digit per clock. A single shared digit-conversion unit is time-multiplexed across all digits, and the block flags illegal BCD digits. It sits between a BCD producer and a 2421 consumer, with valid/ready handshakes on both sides.

---
 rtl/bcd2421_pkg.sv | 17 +
 rtl/bcd2421_digit.sv | 23 ++
 rtl/bcd2421_seq_ctrl.sv | 119 +++++++++++
 tb/tb_bcd2421_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd2421_pkg.sv
// Shared types and constants for the BCD to 2421 sequencing controller.
package bcd2421_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX      = 4'd9;
    localparam logic [DIGIT_W-1:0] THRESH_2421  = 4'd5;
    localparam logic [DIGIT_W-1:0] OFFSET_2421  = 4'd6;
    localparam logic [DIGIT_W-1:0] CODE_INVALID = 4'b0000;

endpackage

// File: rtl/bcd2421_digit.sv
// Single-digit BCD to 2421 converter; flags digits above 9.
module bcd2421_digit
    import bcd2421_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    output logic [DIGIT_W-1:0] code,
    output logic               err
);

    // Low digits pass through, high digits get the 2421 offset, illegal digits map to zero.
    always_comb begin
        code = CODE_INVALID;
        err  = 1'b0;
        if (bcd > BCD_MAX) begin
            err = 1'b1;
        end else if (bcd < THRESH_2421) begin
            code = bcd;
        end else begin
            code = bcd + OFFSET_2421;
        end
    end

endmodule

// File: rtl/bcd2421_seq_ctrl.sv
// Converts a packed BCD word to packed 2421, one digit per clock through a
// single shared digit converter, with valid/ready handshakes on both sides.
module bcd2421_seq_ctrl
    import bcd2421_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*DIGITS-1:0]     in_bcd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*DIGITS-1:0]     out_code,
    output logic [DIGITS-1:0]       out_err,
    output logic                    busy
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_W-1:0]        idx;
    logic [4*DIGITS-1:0]     operand;
    logic [4*DIGITS-1:0]     code_q;
    logic [DIGITS-1:0]       err_q;
    logic [DIGIT_W-1:0]      dig_in;
    logic [DIGIT_W-1:0]      dig_code;
    logic                    dig_err;
    logic                    accept;

    bcd2421_digit u_digit (
        .bcd  (dig_in),
        .code (dig_code),
        .err  (dig_err)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                busy = 1'b1;
                if (idx == IDX_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Route the digit selected by idx into the shared converter.
    always_comb begin
        dig_in = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == i[IDX_W-1:0]) begin
                dig_in = operand[DIGIT_W*i +: DIGIT_W];
            end
        end
    end

    // Operand capture, slot-by-slot result writeback and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand <= '0;
            code_q  <= '0;
            err_q   <= '0;
            idx     <= '0;
        end else if (accept) begin
            operand <= in_bcd;
            code_q  <= '0;
            err_q   <= '0;
            idx     <= '0;
        end else if (state == CONV) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (idx == i[IDX_W-1:0]) begin
                    code_q[DIGIT_W*i +: DIGIT_W] <= dig_code;
                    err_q[i]                     <= dig_err;
                end
            end
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    assign out_code = code_q;
    assign out_err  = err_q;

endmodule

// File: tb/tb_bcd2421_seq_ctrl.sv
// Directed bench for bcd2421_seq_ctrl with a word-level reference model.
module tb_bcd2421_seq_ctrl;

    localparam int DIGITS = 4;
    localparam logic [3:0] TBL [0:9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                                         4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_code;
    logic [3:0]  out_err;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    bcd2421_seq_ctrl #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] ref_code(input logic [15:0] w);
        logic [15:0] r;
        int v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            v = int'(w[4*i +: 4]);
            if (v <= 9) r[4*i +: 4] = TBL[v];
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_err(input logic [15:0] w);
        logic [3:0] e;
        e = '0;
        for (int i = 0; i < DIGITS; i++) e[i] = (int'(w[4*i +: 4]) > 9);
        return e;
    endfunction

    // Word-level model: whole word converted at accept, released DIGITS cycles later.
    bit          m_idle = 1'b1;
    bit          m_done = 1'b0;
    int          m_left = 0;
    logic [15:0] m_pend_c, m_code = '0;
    logic [3:0]  m_pend_e, m_err = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idle = 1'b1; m_done = 1'b0; m_left = 0;
            m_code = '0;   m_err = '0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_pend_c = ref_code(in_bcd);
                m_pend_e = ref_err(in_bcd);
                m_idle   = 1'b0;
                m_left   = DIGITS;
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                m_code = m_pend_c;
                m_err  = m_pend_e;
            end
        end else if (m_done && out_ready) begin
            m_done = 1'b0;
            m_idle = 1'b1;
        end
    end

    // Compare DUT against the model every cycle; result bits only when not mid-conversion.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready, m_idle);
            chk("out_valid", out_valid, m_done);
            chk("busy", busy, !m_idle);
            if (m_left == 0) begin
                chk("out_code", out_code, m_code);
                chk("out_err", out_err, m_err);
            end
        end
    end

    // Accept log for throughput measurement.
    int cyc = 0, acc_n = 0, acc_last = 0, acc_prev = 0;
    always @(posedge clk) begin
        cyc++;
        if (!rst && in_valid && in_ready) begin
            acc_n++;
            acc_prev = acc_last;
            acc_last = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic accept_word(input logic [15:0] w);
        int g = 0;
        while (!in_ready && g < 50) begin step(); g++; end
        chk("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        in_bcd   = w;
        step();
        in_valid = 1'b0;
        in_bcd   = 16'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin step(); lat++; end
        if (!out_valid) chk("done_timeout", out_valid, 1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ready_after_take", in_ready, 1);
        chk("valid_after_take", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int lat, g, base;
        logic [15:0] w, exp;
        logic [3:0] d;

        rst = 1'b1; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_code", out_code, 16'h0000);
        chk("rst_out_err", out_err, 4'h0);
        chk("rst_busy", busy, 0);

        // Basic word and latency.
        accept_word(16'h5927);
        wait_done(lat);
        chk("latency", lat, 4);
        chk("code_5927", out_code, 16'hBF2D);
        chk("err_5927", out_err, 4'b0000);
        take();

        // Illegal digit in position 1.
        accept_word(16'h12A4);
        wait_done(lat);
        chk("code_12A4", out_code, 16'h1204);
        chk("err_12A4", out_err, 4'b0010);
        take();

        // Backpressure: held in DONE for 5 cycles.
        accept_word(16'h0786);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_code", out_code, 16'h0DEC);
            chk("bp_err", out_err, 4'h0);
            chk("bp_in_ready", in_ready, 0);
            step();
        end
        take();

        // Sweep each position over 0..9 with the other digits at 3.
        for (int pos = 0; pos < DIGITS; pos++) begin
            for (int v = 0; v < 10; v++) begin
                w = 16'h3333;
                d = 4'(v);
                w[4*pos +: 4] = d;
                exp = 16'h3333;
                exp[4*pos +: 4] = TBL[v];
                accept_word(w);
                wait_done(lat);
                chk("sweep_code", out_code, exp);
                chk("sweep_err", out_err, 4'h0);
                take();
            end
        end

        // Reset while idx=2 in CONV.
        accept_word(16'h9876);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midrst_code", out_code, 16'h0000);
        chk("midrst_err", out_err, 4'h0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        accept_word(16'h0000);
        wait_done(lat);
        chk("post_rst_code", out_code, 16'h0000);
        chk("post_rst_err", out_err, 4'h0);
        take();

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_bcd    = 16'h9999;
        base      = acc_n;
        g         = 0;
        while (acc_n == base && g < 50) begin step(); g++; end
        chk("b2b_first_accept", acc_n, base + 1);
        in_bcd = 16'h0505;
        g = 0;
        while (!out_valid && g < 50) begin step(); g++; end
        chk("b2b_code_9999", out_code, 16'hFFFF);
        g = 0;
        while (acc_n < base + 2 && g < 50) begin step(); g++; end
        chk("b2b_spacing", acc_last - acc_prev, DIGITS + 2);
        in_valid = 1'b0;
        wait_done(lat);
        chk("b2b_code_0505", out_code, 16'h0B0B);
        chk("b2b_err_0505", out_err, 4'h0);
        step();
        out_ready = 1'b0;
        chk("b2b_in_ready", in_ready, 1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
